// File: rtl/sm_adder_arbiter.sv
// sm_adder_arbiter: round-robin share of one sign-magnitude adder; SM_SAT_EN saturates same-sign overflow
module sm_adder_arbiter #(
  parameter int SIZE = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*SIZE-1:0] req_a,
  input  logic [NREQ*SIZE-1:0] req_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      out_data,
  output logic [IDW-1:0]       out_id
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t          state;
  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  op_id;
  logic [SIZE-1:0] op_a, op_b;
  logic [IDW-1:0]  scan, gnt_idx;
  logic            gnt_any;
  logic [SIZE-1:0] sel_a, sel_b;
  logic [SIZE-2:0] ma, mb, mag_same, mag;
  logic            a_gt, sgn;
  // first valid requester after the round-robin pointer, wrapping at NREQ
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = IDW'((int'(rr) + k) % NREQ);
      if (!gnt_any && req_valid[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = scan;
      end
    end
  end
  // operand mux for the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*SIZE +: SIZE];
        sel_b = req_b[i*SIZE +: SIZE];
      end
    end
  end
  assign req_ready = (rst_n && state == IDLE && gnt_any) ? NREQ'(1) << gnt_idx : '0;
  assign ma   = op_a[SIZE-2:0];
  assign mb   = op_b[SIZE-2:0];
  assign a_gt = ma > mb;
`ifdef SM_SAT_EN
  logic [SIZE-1:0] sum;
  assign sum      = {1'b0, ma} + {1'b0, mb};
  assign mag_same = sum[SIZE-1] ? '1 : sum[SIZE-2:0];
`else
  assign mag_same = ma + mb;
`endif
  assign mag = (op_a[SIZE-1] == op_b[SIZE-1]) ? mag_same : (a_gt ? ma - mb : mb - ma);
  assign sgn = a_gt ? op_a[SIZE-1] : op_b[SIZE-1];
  // grant, compute, hold-until-consumed sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= IDW'(NREQ-1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          op_a  <= sel_a;
          op_b  <= sel_b;
          op_id <= gnt_idx;
          rr    <= gnt_idx;
          state <= EXEC;
        end
        EXEC: begin
          out_data  <= {sgn, mag};
          out_id    <= op_id;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_adder_arbiter.sv
// tb_sm_adder_arbiter: directed plus random checks against a behavioural model of the shared adder
module tb_sm_adder_arbiter;
  localparam int SIZE = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef SM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_a = '0;
  logic [NREQ*SIZE-1:0] req_b = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [SIZE-1:0]      out_data;
  logic [IDW-1:0]       out_id;
  int checks = 0;
  int failures = 0;
  int m_last = NREQ-1;
  int m_busy = 0;
  logic [SIZE-1:0] m_data = '0;
  int m_id = 0;
  logic [NREQ-1:0] acc = '0;

  sm_adder_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [SIZE-1:0] sm_add(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    int ma, mb, m, lim;
    logic s;
    ma  = int'(a[SIZE-2:0]);
    mb  = int'(b[SIZE-2:0]);
    lim = 1 << (SIZE-1);
    if (a[SIZE-1] == b[SIZE-1]) begin
      m = ma + mb;
      if (m >= lim) m = SAT ? lim - 1 : m - lim;
      s = a[SIZE-1];
    end else begin
      m = (ma > mb) ? ma - mb : mb - ma;
      s = (ma > mb) ? a[SIZE-1] : b[SIZE-1];
    end
    return {s, m[SIZE-2:0]};
  endfunction

  function automatic int first_after(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // reference model and per-cycle comparison
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] e_ready;
    if (!rst_n) begin
      m_last = NREQ-1;
      m_busy = 0;
      acc = '0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_id", 32'(out_id), 0);
    end else begin
      g = first_after(m_last, req_valid);
      e_ready = (m_busy == 0 && g >= 0) ? NREQ'(1) << g : '0;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("out_valid", 32'(out_valid), 32'(m_busy == 2));
      if (m_busy == 2) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_id", 32'(out_id), 32'(m_id));
      end
      acc = req_ready & req_valid;
      if (m_busy == 0 && g >= 0) begin
        m_data = sm_add(req_a[g*SIZE +: SIZE], req_b[g*SIZE +: SIZE]);
        m_id = g;
        m_last = g;
        m_busy = 1;
      end else if (m_busy == 1) m_busy = 2;
      else if (m_busy == 2 && out_ready) m_busy = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [SIZE-1:0] exp, input string name);
    req_a[i*SIZE +: SIZE] = a;
    req_b[i*SIZE +: SIZE] = b;
    req_valid = NREQ'(1) << i;
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_grant"}, 32'(req_ready), 32'(NREQ'(1) << i));
    step();
    req_valid = '0;
    @(negedge clk);
    chk({name, "_t1_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({name, "_t2_valid"}, 32'(out_valid), 1);
    chk({name, "_data"}, 32'(out_data), 32'(exp));
    chk({name, "_id"}, 32'(out_id), i);
    step();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(out_valid), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int ids[6];
    int exp3[6] = '{0, 1, 2, 3, 0, 1};
    logic [SIZE-1:0] hd;
    logic [IDW-1:0] hi;
    int n;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_one(0, 16'h0005, 16'h0003, 16'h0008, "basic");
    run_one(0, 16'h8007, 16'h0002, 16'h8005, "mix1");
    run_one(0, 16'h0004, 16'h8004, 16'h8000, "mix_eq");
    run_one(0, 16'h0009, 16'h8003, 16'h0006, "mix2");
    run_one(1, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h0000, "ovf_pos");
    run_one(3, 16'hFFFF, 16'h8001, SAT ? 16'hFFFF : 16'h8000, "ovf_neg");
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*SIZE +: SIZE] = SIZE'($urandom);
      req_b[i*SIZE +: SIZE] = SIZE'($urandom);
    end
    req_valid = '1;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ids[n] = int'(out_id);
        n++;
      end
    end
    chk("rr_count", n, 6);
    for (int j = 0; j < n; j++) chk($sformatf("rr_seq%0d", j), ids[j], exp3[j]);
    step();
    out_ready = 1'b0;
    wait_valid("hold");
    hd = out_data;
    hi = out_id;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(hd));
      chk("hold_id", 32'(out_id), 32'(hi));
      chk("hold_ready", 32'(req_ready), 0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid", 32'(out_valid), 1);
    step();
    @(negedge clk);
    chk("regrant_onehot", 32'($onehot(req_ready)), 1);
    step();
    req_valid = '0;
    repeat (4) step();
    req_a[2*SIZE +: SIZE] = 16'h0011;
    req_b[2*SIZE +: SIZE] = 16'h0022;
    req_a[1*SIZE +: SIZE] = 16'h0101;
    req_b[1*SIZE +: SIZE] = 16'h8001;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rst_mid_grant", 32'(req_ready), 32'h4);
    step();
    rst_n = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_valid", 32'(out_valid), 0);
    chk("rst_after_grant", 32'(req_ready), 32'h2);
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = acc[i] ? ($urandom_range(1) == 1) : ($urandom_range(9) < 3);
          req_a[i*SIZE +: SIZE] = SIZE'($urandom);
          req_b[i*SIZE +: SIZE] = ($urandom_range(3) == 0) ? req_a[i*SIZE +: SIZE] ^ 16'h8000 : SIZE'($urandom);
        end
      end
      out_ready = ($urandom_range(2) != 0);
    end
    step();
    req_valid = '0;
    out_ready = 1'b1;
    repeat (6) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
